// File: rtl/key_cursor_ctrl.sv
// Minesweeper cursor/command controller fed by the PS/2 decoder event stream.
// Tracks a clamped or wrapping cursor, auto-repeats held arrows and emits command pulses.
module key_cursor_ctrl #(
    parameter int ROWS       = 16,
    parameter int COLS       = 16,
    parameter int ROW_W      = 4,
    parameter int COL_W      = 4,
    parameter int WRAP       = 0,
    parameter int REP_DELAY  = 50_000_000,
    parameter int REP_PERIOD = 10_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [8:0]        last_change,
    input  logic [511:0]      key_down,
    input  logic              enable,
    output logic [ROW_W-1:0]  cur_row,
    output logic [COL_W-1:0]  cur_col,
    output logic              cmd_valid,
    output logic [1:0]        cmd_op,
    output logic [ROW_W-1:0]  cmd_row,
    output logic [COL_W-1:0]  cmd_col
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    localparam logic [1:0] OP_REVEAL  = 2'b00;
    localparam logic [1:0] OP_FLAG    = 2'b01;
    localparam logic [1:0] OP_RESTART = 2'b11;

    localparam int CNT_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [CNT_W-1:0] CNT_DELAY  = CNT_W'(REP_DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_PERIOD = CNT_W'(REP_PERIOD - 1);

    // Returns {is_direction, dir}; dir encodes 00 up, 01 down, 10 left, 11 right.
    function automatic logic [2:0] dir_decode(input logic [8:0] code);
        logic [2:0] res;
        case (code)
            9'h175, 9'h01D: res = 3'b100;
            9'h172, 9'h01B: res = 3'b101;
            9'h16B, 9'h01C: res = 3'b110;
            9'h174, 9'h023: res = 3'b111;
            default:        res = 3'b000;
        endcase
        return res;
    endfunction

    function automatic logic is_reveal(input logic [8:0] code);
        return (code == 9'h05A) || (code == 9'h029);
    endfunction

    function automatic logic is_flag(input logic [8:0] code);
        return code == 9'h02B;
    endfunction

    function automatic logic is_restart(input logic [8:0] code);
        return code == 9'h02D;
    endfunction

    function automatic logic [ROW_W-1:0] row_step(input logic [ROW_W-1:0] r, input logic down);
        logic [ROW_W-1:0] res;
        if (down) begin
            if (r == ROW_LAST) begin
                res = (WRAP != 0) ? {ROW_W{1'b0}} : r;
            end else begin
                res = r + ROW_W'(1);
            end
        end else begin
            if (r == {ROW_W{1'b0}}) begin
                res = (WRAP != 0) ? ROW_LAST : r;
            end else begin
                res = r - ROW_W'(1);
            end
        end
        return res;
    endfunction

    function automatic logic [COL_W-1:0] col_step(input logic [COL_W-1:0] c, input logic right);
        logic [COL_W-1:0] res;
        if (right) begin
            if (c == COL_LAST) begin
                res = (WRAP != 0) ? {COL_W{1'b0}} : c;
            end else begin
                res = c + COL_W'(1);
            end
        end else begin
            if (c == {COL_W{1'b0}}) begin
                res = (WRAP != 0) ? COL_LAST : c;
            end else begin
                res = c - COL_W'(1);
            end
        end
        return res;
    endfunction

    logic [1:0]       state_r, state_nxt_s;
    logic [8:0]       hold_r, hold_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [ROW_W-1:0] row_r, row_nxt_s;
    logic [COL_W-1:0] col_r, col_nxt_s;
    logic             cmd_valid_r, cmd_valid_nxt_s;
    logic [1:0]       cmd_op_r, cmd_op_nxt_s;
    logic [ROW_W-1:0] cmd_row_r, cmd_row_nxt_s;
    logic [COL_W-1:0] cmd_col_r, cmd_col_nxt_s;

    logic             press_s;
    logic             held_s;
    logic [2:0]       ev_dir_s;
    logic [2:0]       hold_dir_s;
    logic             move_s;
    logic [1:0]       move_dir_s;

    // Event classification against the current held-key vector.
    always_comb begin
        press_s    = key_valid && key_down[last_change];
        held_s     = key_down[hold_r];
        ev_dir_s   = dir_decode(last_change);
        hold_dir_s = dir_decode(hold_r);
    end

    // Next-state: restart beats everything, enable gates moves/commands, a fresh press beats the repeat tick.
    always_comb begin
        state_nxt_s     = state_r;
        hold_nxt_s      = hold_r;
        cnt_nxt_s       = cnt_r;
        cmd_valid_nxt_s = 1'b0;
        cmd_op_nxt_s    = cmd_op_r;
        cmd_row_nxt_s   = cmd_row_r;
        cmd_col_nxt_s   = cmd_col_r;
        move_s          = 1'b0;
        move_dir_s      = 2'b00;

        if (press_s && is_restart(last_change)) begin
            state_nxt_s     = ST_IDLE;
            cnt_nxt_s       = {CNT_W{1'b0}};
            cmd_valid_nxt_s = 1'b1;
            cmd_op_nxt_s    = OP_RESTART;
            cmd_row_nxt_s   = row_r;
            cmd_col_nxt_s   = col_r;
        end else if (!enable) begin
            state_nxt_s = ST_IDLE;
        end else begin
            if (press_s && ev_dir_s[2]) begin
                move_s      = 1'b1;
                move_dir_s  = ev_dir_s[1:0];
                hold_nxt_s  = last_change;
                cnt_nxt_s   = CNT_DELAY;
                state_nxt_s = ST_DELAY;
            end else if (state_r != ST_IDLE) begin
                if (!held_s || !hold_dir_s[2]) begin
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r == {CNT_W{1'b0}}) begin
                    move_s      = 1'b1;
                    move_dir_s  = hold_dir_s[1:0];
                    cnt_nxt_s   = CNT_PERIOD;
                    state_nxt_s = ST_REPEAT;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end else begin
                state_nxt_s = ST_IDLE;
            end

            if (press_s && (is_reveal(last_change) || is_flag(last_change))) begin
                cmd_valid_nxt_s = 1'b1;
                cmd_op_nxt_s    = is_flag(last_change) ? OP_FLAG : OP_REVEAL;
                cmd_row_nxt_s   = row_r;
                cmd_col_nxt_s   = col_r;
            end else begin
                cmd_valid_nxt_s = 1'b0;
            end
        end
    end

    // Cursor update; restart forces the origin.
    always_comb begin
        row_nxt_s = row_r;
        col_nxt_s = col_r;
        if (press_s && is_restart(last_change)) begin
            row_nxt_s = {ROW_W{1'b0}};
            col_nxt_s = {COL_W{1'b0}};
        end else if (move_s) begin
            case (move_dir_s)
                2'b00:   row_nxt_s = row_step(row_r, 1'b0);
                2'b01:   row_nxt_s = row_step(row_r, 1'b1);
                2'b10:   col_nxt_s = col_step(col_r, 1'b0);
                2'b11:   col_nxt_s = col_step(col_r, 1'b1);
                default: row_nxt_s = row_r;
            endcase
        end else begin
            row_nxt_s = row_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            hold_r      <= 9'd0;
            cnt_r       <= {CNT_W{1'b0}};
            row_r       <= {ROW_W{1'b0}};
            col_r       <= {COL_W{1'b0}};
            cmd_valid_r <= 1'b0;
            cmd_op_r    <= 2'b00;
            cmd_row_r   <= {ROW_W{1'b0}};
            cmd_col_r   <= {COL_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            hold_r      <= hold_nxt_s;
            cnt_r       <= cnt_nxt_s;
            row_r       <= row_nxt_s;
            col_r       <= col_nxt_s;
            cmd_valid_r <= cmd_valid_nxt_s;
            cmd_op_r    <= cmd_op_nxt_s;
            cmd_row_r   <= cmd_row_nxt_s;
            cmd_col_r   <= cmd_col_nxt_s;
        end
    end

    assign cur_row   = row_r;
    assign cur_col   = col_r;
    assign cmd_valid = cmd_valid_r;
    assign cmd_op    = cmd_op_r;
    assign cmd_row   = cmd_row_r;
    assign cmd_col   = cmd_col_r;

endmodule

// File: tb/tb_key_cursor_ctrl.sv
// Directed bench for key_cursor_ctrl: a clamping and a wrapping instance share one stimulus stream.
module tb_key_cursor_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic [8:0]   last_change;
    logic [511:0] key_down;
    logic         enable;

    logic [3:0] r0, c0, cr0, cc0, r1, c1, cr1, cc1;
    logic       cv0, cv1;
    logic [1:0] op0, op1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    key_cursor_ctrl #(.ROWS(16), .COLS(16), .ROW_W(4), .COL_W(4), .WRAP(0),
                      .REP_DELAY(8), .REP_PERIOD(4)) dut0 (
        .clk(clk), .rst(rst), .key_valid(key_valid), .last_change(last_change),
        .key_down(key_down), .enable(enable), .cur_row(r0), .cur_col(c0),
        .cmd_valid(cv0), .cmd_op(op0), .cmd_row(cr0), .cmd_col(cc0));

    key_cursor_ctrl #(.ROWS(16), .COLS(16), .ROW_W(4), .COL_W(4), .WRAP(1),
                      .REP_DELAY(8), .REP_PERIOD(4)) dut1 (
        .clk(clk), .rst(rst), .key_valid(key_valid), .last_change(last_change),
        .key_down(key_down), .enable(enable), .cur_row(r1), .cur_col(c1),
        .cmd_valid(cv1), .cmd_op(op1), .cmd_row(cr1), .cmd_col(cc1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One decoder event lasting a single cycle; outputs are valid on return.
    task automatic ev(input logic [8:0] code, input logic dn);
        key_down[code] = dn;
        last_change    = code;
        key_valid      = 1'b1;
        tick();
        key_valid      = 1'b0;
    endtask

    task automatic tap(input logic [8:0] code);
        ev(code, 1'b1);
        ev(code, 1'b0);
    endtask

    initial begin
        int exp_row;
        logic bad;
        rst = 1'b1; key_valid = 1'b0; last_change = 9'd0; key_down = '0; enable = 1'b1;
        tick();
        tick();
        chk("rst_row", r0, 0);
        chk("rst_col", c0, 0);
        chk("rst_cmd_valid", cv0, 0);
        chk("rst_cmd_op", op0, 0);
        chk("rst_cmd_row", cr0, 0);
        chk("rst_cmd_col", cc0, 0);
        rst = 1'b0;
        tick();

        ev(9'h174, 1'b1);
        chk("right_col", c0, 1);
        chk("right_row", r0, 0);
        chk("right_no_cmd", cv0, 0);
        ev(9'h174, 1'b0);

        for (int i = 0; i < 14; i++) tap(9'h023);
        chk("col15_clamp_inst", c0, 15);
        chk("col15_wrap_inst", c1, 15);
        ev(9'h174, 1'b1);
        chk("right_edge_clamp", c0, 15);
        chk("right_edge_wrap", c1, 0);
        ev(9'h174, 1'b0);

        ev(9'h175, 1'b1);
        chk("up_edge_clamp", r0, 0);
        chk("up_edge_wrap", r1, 15);
        ev(9'h175, 1'b0);

        ev(9'h02D, 1'b1);
        chk("restart_valid", cv0, 1);
        chk("restart_op", op0, 3);
        chk("restart_row", r1, 0);
        chk("restart_col", c0, 0);
        chk("restart_cmd_col0", cc0, 15);
        chk("restart_cmd_row1", cr1, 15);
        ev(9'h02D, 1'b0);
        chk("release_no_cmd", cv0, 0);

        // Hold Down: moves at t+1, t+9, t+13, t+17
        ev(9'h172, 1'b1);
        chk("hold_first_move", r0, 1);
        for (int k = 1; k <= 19; k++) begin
            tick();
            exp_row = 1 + ((k >= 8) ? 1 : 0) + ((k >= 12) ? 1 : 0) + ((k >= 16) ? 1 : 0);
            chk($sformatf("hold_row_k%0d", k), r0, exp_row);
        end
        ev(9'h172, 1'b0);
        for (int k = 0; k < 10; k++) tick();
        chk("after_release_row", r0, 4);

        tap(9'h02D);
        for (int i = 0; i < 3; i++) tap(9'h01B);
        for (int i = 0; i < 5; i++) tap(9'h174);
        ev(9'h029, 1'b1);
        chk("reveal_valid", cv0, 1);
        chk("reveal_op", op0, 0);
        chk("reveal_row", cr0, 3);
        chk("reveal_col", cc0, 5);
        tick();
        chk("reveal_one_cycle", cv0, 0);
        ev(9'h029, 1'b0);
        ev(9'h02B, 1'b1);
        chk("flag_valid", cv0, 1);
        chk("flag_op", op0, 1);
        ev(9'h02B, 1'b0);

        enable = 1'b0;
        ev(9'h16B, 1'b1);
        chk("dis_left_col", c0, 5);
        chk("dis_left_no_cmd", cv0, 0);
        ev(9'h16B, 1'b0);
        ev(9'h05A, 1'b1);
        chk("dis_enter_no_cmd", cv0, 0);
        ev(9'h05A, 1'b0);
        ev(9'h02D, 1'b1);
        chk("dis_restart_valid", cv0, 1);
        chk("dis_restart_op", op0, 3);
        chk("dis_restart_row", r0, 0);
        chk("dis_restart_col", c0, 0);
        chk("dis_restart_cmd_row", cr0, 3);
        ev(9'h02D, 1'b0);
        enable = 1'b1;

        // Hold Right, then Up mid-DELAY takes over the repeat
        for (int i = 0; i < 3; i++) tap(9'h172);
        ev(9'h174, 1'b1);
        chk("hold_right_col", c0, 1);
        tick(); tick(); tick();
        ev(9'h175, 1'b1);
        chk("up_override_row", r0, 2);
        for (int k = 0; k < 7; k++) tick();
        chk("right_stopped_col", c0, 1);
        chk("up_waiting_row", r0, 2);
        tick();
        chk("up_repeat_row", r0, 1);
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("midrep_rst_row", r0, 0);
        chk("midrep_rst_col", c0, 0);
        chk("midrep_rst_valid", cv0, 0);
        tick();
        rst = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (r0 != 4'd0 || c0 != 4'd0 || cv0 != 1'b0) bad = 1'b1;
        end
        chk("post_rst_quiet", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
